// File: rtl/uart_pkg.sv
// Shared types and constants for the serial transmit path.
// UART_SENDER_PARITY_EN selects an 8E1 frame instead of 8N1.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_BITS = 8;

`ifdef UART_SENDER_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_sender_if.sv
// Producer-side bundle of uart_sender plus line/status and debug visibility.
// Handshake: a 0->1 transition of start enqueues data; there is no ready, a push
// that finds the FIFO full (with no same-cycle pop) is dropped and flagged in overflow.
interface uart_sender_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]            data;
    logic                  start;
    logic                  out;
    logic                  busy;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    uart_pkg::tx_state_t   state;
    logic [FIFO_AW:0]      count;

    modport master (
        output data, start,
        input  out, busy, empty, full, overflow, state, count
    );

    modport slave (
        input  data, start,
        output out, busy, empty, full, overflow, state, count
    );
endinterface

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO, depth 2^FIFO_AW; dout is valid whenever !empty.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_AW + 1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/uart_sender.sv
// Buffered LSB-first serial transmitter on an idle-high line, fed by start edges.
// Define UART_SENDER_PARITY_EN to insert an even parity bit (8E1).
module uart_sender
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 10417,
    parameter int FIFO_AW  = 4
) (
    input  logic          sysclk,
    input  logic          reset,
    uart_sender_if.slave  bus
);
    localparam int            CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             start_q;
    logic             out_q, out_d;
    logic             busy_q;
    logic             overflow_q;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [FIFO_AW:0] fifo_count;

    assign push    = bus.start & ~start_q;
    assign bit_end = (cnt_q == CNT_LAST);

    byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (sysclk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state logic; the counter restarts on every bit boundary and state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_SENDER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_SENDER_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Line value is decoded from the next state so out itself is a clean flop.
    always_comb begin
        out_d = 1'b1;
        unique case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shreg_d[idx_d];
`ifdef UART_SENDER_PARITY_EN
            PARITY:  out_d = ^shreg_d;
`endif
            default: out_d = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            start_q    <= 1'b0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            start_q    <= bus.start;
            out_q      <= out_d;
            busy_q     <= (state_d != IDLE);
            overflow_q <= overflow_q | (push & fifo_full & ~pop);
        end
    end

    assign bus.out      = out_q;
    assign bus.busy     = busy_q;
    assign bus.empty    = fifo_empty;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;
    assign bus.state    = state_q;
    assign bus.count    = fifo_count;
endmodule

// File: doc/uart_sender.md
# uart_sender

Buffered 8N1 serial transmitter, the outbound end of the keyboard serial link: it accepts bytes from a producer such as the tweetboard playback logic, queues them in a small FIFO and shifts each one out LSB-first on an idle-high line. Bytes are enqueued on the rising edge of `start`, so a producer that holds `start` high for many cycles still enqueues exactly one byte. It sits between the tweetboard and the board's serial output pin.

## Interface
- `BAUD_DIV`, 10417, sysclk cycles per bit period; legal range ≥ 2.
- `FIFO_AW`, 4, FIFO address width; depth = 2^FIFO_AW = 16.
- `sysclk`  in  1  system clock; all logic is on the posedge.
- `reset`  in  1  synchronous, active-low reset.
- `data`  in  8  byte to enqueue; sampled on the cycle the `start` rising edge is detected.
- `start`  in  1  enqueue request; the 0→1 transition enqueues one byte.
- `out`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is on the line (start bit through stop bit).
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds 2^FIFO_AW bytes.
- `overflow`  out  1  sticky: set when an enqueue is dropped; cleared only by reset.

## Operation
- Edge detect: a registered `start_q` is kept; a push occurs when `start & ~start_q`. `start_q` resets to 0, so `start` already high when reset is released counts as an edge on the first cycle.
- Push while full is dropped and sets `overflow`, unless a pop happens in the same cycle; that push is accepted.
- States: IDLE, START, DATA, STOP, plus PARITY when the parity feature is enabled.
  - IDLE & !empty → pop into the shift register, go to START.
  - START → DATA after one bit period.
  - DATA → STOP after 8 bit periods; bit index 0..7.
  - STOP → IDLE, or directly to START if the FIFO is non-empty on the last STOP cycle.
- Line value per state: IDLE 1, START 0, DATA `shreg[idx]`, STOP 1. `out` is a registered output with no combinational glitches.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and is cleared on every state entry.
  - A bit boundary occurs when the counter equals BAUD_DIV-1.
  - The counter width is $clog2(BAUD_DIV).
- FIFO count width is FIFO_AW+1. Pointers wrap modulo 2^FIFO_AW.
- Reset takes effect on the next edge even mid-frame: `out` returns to 1, the FIFO is emptied, and the block returns to IDLE. No partial frame resumes after reset.

## Timing
- Reset values: `out`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0; state IDLE; counters 0.
- Push edge at cycle n → `empty` falls at n+1.
- If idle at n+1, the pop occurs at n+1, `out` goes low and `busy` goes high at n+2. Enqueue-to-start-bit latency is 2 cycles.
- Each bit lasts exactly BAUD_DIV cycles. A frame is 10·BAUD_DIV cycles (11·BAUD_DIV with parity).
- Back-to-back frames have no idle gap: the next start bit begins the cycle after the last stop cycle.
- `busy` falls on the cycle `out` re-enters IDLE, and not at all between back-to-back frames.
- `full` and `empty` update one cycle after the push or pop that changes them.

## Configuration
- `UART_SENDER_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - It carries even parity, the XOR of the 8 data bits.
  - Frame is 8E1, 11 bit periods.
- Macro not defined: frame is 8N1 and no parity logic is present.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_FRAME_BITS`, which is 10, or 11 when the parity macro is defined.
- One sub-module, `byte_fifo`:
  - synchronous FIFO with push, pop, din, dout, full, empty and count;
  - parameterized by FIFO_AW;
  - first-word-fall-through, so dout is valid whenever !empty.
- The edge detect, baud counter, FSM and shift register live in `uart_sender`.

## Test plan
- BAUD_DIV=4, push 0x41 → `out` is 1 for 2 cycles after the edge, then 0 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 1. `busy` is high for 40 cycles.
- Hold `start` high for 100 cycles with `data`=0x55 → exactly one frame is sent; `empty` is high again after the pop.
- Push 0x01, 0x02, 0x03 on consecutive edges → three frames with no idle cycle between the stop and next start bits; `busy` stays high for 120 cycles (BAUD_DIV=4).
- Fill with 16 pushes while the first frame is in flight (the first pop leaves 15 queued), then push 2 more → `full`=1. The 17th push is accepted, the 18th is dropped, `overflow`=1 and stays 1. Exactly 17 frames are sent.
- Assert `reset`=0 for 1 cycle during DATA bit 3 → `out`=1, `busy`=0, `empty`=1 next cycle; no further line activity.
- With `UART_SENDER_PARITY_EN`, push 0x07 → parity bit = 1, then stop bit; frame length 44 cycles (BAUD_DIV=4).
